// File: rtl/ct_ebiu_cawt_ctrl.sv
// rtl/ct_ebiu_cawt_ctrl.sv - CA write table allocation/retire controller with sync drain FSM
module ct_ebiu_cawt_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int IDW       = 3
) (
  input  logic                 cawt_ctrl_clk,
  input  logic                 cpurst_b,
  input  logic                 vb_cawt_create_req,
  input  logic [ENTRY_NUM-1:0] ca_wr_addr_hit_vec,
  input  logic [ENTRY_NUM-1:0] cawt_vld_vec,
  output logic                 cawt_create_gnt,
  output logic [IDW-1:0]       cawt_create_id,
  output logic [ENTRY_NUM-1:0] cawt_create_en_vec,
  output logic [ENTRY_NUM-1:0] cawt_create_dp_en_vec,
  input  logic                 pad_ebiu_bvalid,
  input  logic [IDW-1:0]       pad_ebiu_bid,
  output logic                 ebiu_pad_bready,
  output logic [ENTRY_NUM-1:0] cawt_pop_en_vec,
  output logic [IDW:0]         cawt_cnt,
  output logic                 cawt_full,
  output logic                 cawt_empty,
  input  logic                 ciu_cawt_sync_req,
  output logic                 cawt_ciu_sync_ack,
  output logic                 cawt_bid_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ACK, ST_WAIT} state_t;

  localparam logic [IDW:0] CNT_MAX = (IDW+1)'(ENTRY_NUM);

  state_t         state_q, state_d;
  logic [IDW:0]   cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           free_vld;
  logic [IDW-1:0] free_id;
  logic           pop_vld;

  // Lowest-index free entry; scanning from the top lets the lowest index win
  always_comb begin
    free_vld = 1'b0;
    free_id  = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!cawt_vld_vec[i]) begin
        free_vld = 1'b1;
        free_id  = IDW'(i);
      end
    end
  end

  // Grant/pop strobes, occupancy count, sticky bid error and drain FSM next state
  always_comb begin
    state_d               = state_q;
    cnt_d                 = cnt_q;
    err_d                 = err_q;
    cawt_create_gnt       = 1'b0;
    cawt_create_id        = '0;
    cawt_create_en_vec    = '0;
    cawt_create_dp_en_vec = '0;
    cawt_pop_en_vec       = '0;
    cawt_ciu_sync_ack     = 1'b0;

    // Index-hit stall keeps same-index CA accesses ordered behind the outstanding one
    cawt_create_gnt = vb_cawt_create_req & (state_q != ST_DRAIN) & free_vld
                    & ~|ca_wr_addr_hit_vec;
    if (cawt_create_gnt) begin
      cawt_create_id        = free_id;
      cawt_create_en_vec    = ENTRY_NUM'(1) << free_id;
      cawt_create_dp_en_vec = ENTRY_NUM'(1) << free_id;
    end

    // bready is tied high, so every bvalid is a handshake; unknown entries only flag an error
    pop_vld = pad_ebiu_bvalid & cawt_vld_vec[pad_ebiu_bid];
    if (pop_vld) begin
      cawt_pop_en_vec = ENTRY_NUM'(1) << pad_ebiu_bid;
    end
    if (pad_ebiu_bvalid && !cawt_vld_vec[pad_ebiu_bid]) begin
      err_d = 1'b1;
    end

    case ({cawt_create_gnt, pop_vld})
      2'b10:   if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0)      cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      ST_IDLE:  if (ciu_cawt_sync_req) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == '0 && !pop_vld) state_d = ST_ACK;
      ST_ACK: begin
        cawt_ciu_sync_ack = 1'b1;
        state_d           = ST_WAIT;
      end
      ST_WAIT:  if (!ciu_cawt_sync_req) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge cawt_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ebiu_pad_bready = 1'b1;
  assign cawt_cnt        = cnt_q;
  assign cawt_full       = (cnt_q == CNT_MAX);
  assign cawt_empty      = (cnt_q == '0);
  assign cawt_bid_err    = err_q;

  // The count must never be asked to move past either end
  a_cnt_no_overflow: assert property (@(posedge cawt_ctrl_clk) disable iff (!cpurst_b)
    !(cawt_create_gnt && !pop_vld && cnt_q == CNT_MAX));
  a_cnt_no_underflow: assert property (@(posedge cawt_ctrl_clk) disable iff (!cpurst_b)
    !(pop_vld && !cawt_create_gnt && cnt_q == '0));

endmodule
